cpu_pc_seq: RTL and testbench

//   Program-counter sequencer that drives the jump unit. Each enabled cycle it

---
 rtl/cpu_pc_seq_if.sv | 33 +++
 rtl/cpu_pc_seq.sv | 133 +++++++++++++
 tb/tb_cpu_pc_seq.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_pc_seq_if.sv
// Decoder-to-sequencer bus for cpu_pc_seq: op strobe, targets and base load in;
// registered PC, base, link-stack view and status out.
interface cpu_pc_seq_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned STK_DEPTH = 4
);
    localparam int unsigned SPW = $clog2(STK_DEPTH) + 1;

    logic             EN;
    logic [2:0]       OP;
    logic [WIDTH-1:0] TARGET;
    logic             BASE_LD;
    logic [WIDTH-1:0] BASE_DATA;
    logic             RESUME;

    logic [WIDTH-1:0] PC;
    logic [WIDTH-1:0] BASE_REG;
    logic [WIDTH-1:0] LR_TOP;
    logic [SPW-1:0]   SP;
    logic [1:0]       STATE;
    logic             STK_OVF;
    logic             STK_UNF;

    modport master (
        output EN, OP, TARGET, BASE_LD, BASE_DATA, RESUME,
        input  PC, BASE_REG, LR_TOP, SP, STATE, STK_OVF, STK_UNF
    );

    modport slave (
        input  EN, OP, TARGET, BASE_LD, BASE_DATA, RESUME,
        output PC, BASE_REG, LR_TOP, SP, STATE, STK_OVF, STK_UNF
    );
endinterface

// File: rtl/cpu_pc_seq.sv
// Program-counter sequencer: NEXT/JMP/JMPB/CALL/RET/HALT with a base register
// and a LIFO link stack; every output is registered with one-cycle latency.
module cpu_pc_seq #(
    parameter int unsigned   WIDTH     = 8,
    parameter int unsigned   STK_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input logic          CLK,
    input logic          RST,
    cpu_pc_seq_if.slave  bus
);
    localparam int unsigned IW  = $clog2(STK_DEPTH);
    localparam int unsigned SPW = IW + 1;

    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_HALT  = 2'b01;
    localparam logic [1:0] ST_FAULT = 2'b10;

    localparam logic [2:0] OP_NEXT = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_JMPB = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b101;

    localparam logic [SPW-1:0] SP_FULL = SPW'(STK_DEPTH);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [SPW-1:0]   sp_q, sp_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] stk_q [STK_DEPTH];
    logic [WIDTH-1:0] stk_d [STK_DEPTH];

    logic [WIDTH-1:0] pc_inc;
    logic [IW-1:0]    top_idx;
    logic [WIDTH-1:0] lr_top;

    assign pc_inc  = pc_q + WIDTH'(1);
    assign top_idx = IW'(sp_q - SPW'(1));
    assign lr_top  = (sp_q != '0) ? stk_q[top_idx] : '0;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        base_d  = base_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        stk_d   = stk_q;

        // JMPB below reads base_q, so a same-cycle load only affects later ops
        if (bus.BASE_LD) begin
            base_d = bus.BASE_DATA;
        end

        case (state_q)
            ST_RUN: begin
                if (bus.EN) begin
                    case (bus.OP)
                        OP_JMP:  pc_d = bus.TARGET;
                        OP_JMPB: pc_d = base_q + bus.TARGET;
                        OP_CALL: begin
                            if (sp_q == SP_FULL) begin
                                ovf_d   = 1'b1;
                                state_d = ST_FAULT;
                            end else begin
                                stk_d[sp_q[IW-1:0]] = pc_inc;
                                sp_d                = sp_q + SPW'(1);
                                pc_d                = bus.TARGET;
                            end
                        end
                        OP_RET: begin
                            if (sp_q == '0) begin
                                unf_d   = 1'b1;
                                state_d = ST_FAULT;
                            end else begin
                                pc_d = lr_top;
                                sp_d = sp_q - SPW'(1);
                            end
                        end
                        OP_HALT: state_d = ST_HALT;
                        default: pc_d = pc_inc;
                    endcase
                end
            end
            ST_HALT: begin
                if (bus.RESUME) begin
                    pc_d    = pc_inc;
                    state_d = ST_RUN;
                end
            end
            default: begin
                // FAULT (and the unused encoding) hold everything until reset
                state_d = ST_FAULT;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_VEC;
            base_q  <= '0;
            sp_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int unsigned i = 0; i < STK_DEPTH; i++) begin
                stk_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            base_q  <= base_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            for (int unsigned i = 0; i < STK_DEPTH; i++) begin
                stk_q[i] <= stk_d[i];
            end
        end
    end

    assign bus.PC       = pc_q;
    assign bus.BASE_REG = base_q;
    assign bus.LR_TOP   = lr_top;
    assign bus.SP       = sp_q;
    assign bus.STATE    = state_q;
    assign bus.STK_OVF  = ovf_q;
    assign bus.STK_UNF  = unf_q;
endmodule

// File: tb/tb_cpu_pc_seq.sv
// Directed self-checking bench for cpu_pc_seq (WIDTH=8, STK_DEPTH=4).
module tb_cpu_pc_seq;
    localparam logic [2:0] OP_NEXT = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_JMPB = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b101;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cpu_pc_seq_if #(.WIDTH(8), .STK_DEPTH(4)) bus ();

    cpu_pc_seq #(.WIDTH(8), .STK_DEPTH(4), .RESET_VEC(8'h00)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    task automatic drive(input logic en, input logic [2:0] op, input logic [7:0] tgt);
        bus.EN     = en;
        bus.OP     = op;
        bus.TARGET = tgt;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        drive(1'b0, OP_NEXT, 8'h00);
        bus.BASE_LD   = 1'b0;
        bus.BASE_DATA = 8'h00;
        bus.RESUME    = 1'b0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.PC !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h expected %h", bus.PC, 8'h00); end
        checks++; if (bus.SP !== 3'd0) begin errors++; $display("FAIL reset_sp: got %0d expected 0", bus.SP); end
        checks++; if (bus.STATE !== 2'b00) begin errors++; $display("FAIL reset_state: got %b expected 00", bus.STATE); end
        checks++; if (bus.BASE_REG !== 8'h00 || bus.LR_TOP !== 8'h00) begin errors++; $display("FAIL reset_base_lr: got %h/%h expected 00/00", bus.BASE_REG, bus.LR_TOP); end
        checks++; if (bus.STK_OVF !== 1'b0 || bus.STK_UNF !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b%b expected 00", bus.STK_OVF, bus.STK_UNF); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_next;
        logic [7:0] exp_pc [3];
        exp_pc[0] = 8'h01; exp_pc[1] = 8'h02; exp_pc[2] = 8'h03;
        do_reset();
        drive(1'b1, OP_NEXT, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.PC !== exp_pc[i]) begin errors++; $display("FAIL next_pc%0d: got %h expected %h", i, bus.PC, exp_pc[i]); end
        end
        checks++; if (bus.SP !== 3'd0 || bus.STATE !== 2'b00) begin errors++; $display("FAIL next_sp_state: got %0d/%b expected 0/00", bus.SP, bus.STATE); end
        drive(1'b1, 3'b110, 8'h00);
        tick();
        checks++; if (bus.PC !== 8'h04) begin errors++; $display("FAIL op110_as_next: got %h expected 04", bus.PC); end
        drive(1'b1, 3'b111, 8'h00);
        tick();
        checks++; if (bus.PC !== 8'h05) begin errors++; $display("FAIL op111_as_next: got %h expected 05", bus.PC); end
        drive(1'b0, OP_JMP, 8'h77);
        tick(); tick();
        checks++; if (bus.PC !== 8'h05) begin errors++; $display("FAIL en_low_hold: got %h expected 05", bus.PC); end
    endtask

    task automatic test_jmpb;
        do_reset();
        bus.BASE_LD = 1'b1; bus.BASE_DATA = 8'h0A;
        drive(1'b1, OP_JMPB, 8'h12);
        tick();
        checks++; if (bus.PC !== 8'h12) begin errors++; $display("FAIL jmpb_old_base: got %h expected 12", bus.PC); end
        checks++; if (bus.BASE_REG !== 8'h0A) begin errors++; $display("FAIL base_load: got %h expected 0A", bus.BASE_REG); end
        bus.BASE_LD = 1'b0;
        drive(1'b1, OP_JMPB, 8'hA7);
        tick();
        checks++; if (bus.PC !== 8'hB1) begin errors++; $display("FAIL jmpb_new_base: got %h expected B1", bus.PC); end
        bus.BASE_LD = 1'b1; bus.BASE_DATA = 8'hF0;
        drive(1'b0, OP_NEXT, 8'h00);
        tick();
        bus.BASE_LD = 1'b0;
        drive(1'b1, OP_JMPB, 8'h20);
        tick();
        checks++; if (bus.PC !== 8'h10) begin errors++; $display("FAIL jmpb_wrap: got %h expected 10", bus.PC); end
    endtask

    task automatic test_call_ret;
        do_reset();
        drive(1'b1, OP_JMP, 8'h10); tick();
        drive(1'b1, OP_CALL, 8'h40); tick();
        checks++; if (bus.PC !== 8'h40 || bus.SP !== 3'd1 || bus.LR_TOP !== 8'h11) begin errors++; $display("FAIL call1: got pc=%h sp=%0d lr=%h expected 40/1/11", bus.PC, bus.SP, bus.LR_TOP); end
        drive(1'b1, OP_CALL, 8'h69); tick();
        checks++; if (bus.PC !== 8'h69 || bus.SP !== 3'd2 || bus.LR_TOP !== 8'h41) begin errors++; $display("FAIL call2: got pc=%h sp=%0d lr=%h expected 69/2/41", bus.PC, bus.SP, bus.LR_TOP); end
        drive(1'b1, OP_RET, 8'h00); tick();
        checks++; if (bus.PC !== 8'h41 || bus.SP !== 3'd1 || bus.LR_TOP !== 8'h11) begin errors++; $display("FAIL ret1: got pc=%h sp=%0d lr=%h expected 41/1/11", bus.PC, bus.SP, bus.LR_TOP); end
        tick();
        checks++; if (bus.PC !== 8'h11 || bus.SP !== 3'd0 || bus.LR_TOP !== 8'h00) begin errors++; $display("FAIL ret2: got pc=%h sp=%0d lr=%h expected 11/0/00", bus.PC, bus.SP, bus.LR_TOP); end
        checks++; if (bus.STATE !== 2'b00) begin errors++; $display("FAIL call_ret_state: got %b expected 00", bus.STATE); end
    endtask

    task automatic test_overflow;
        logic [7:0] tgt [4];
        logic [7:0] lr  [4];
        tgt[0] = 8'h30; tgt[1] = 8'h31; tgt[2] = 8'h32; tgt[3] = 8'hFF;
        lr[0]  = 8'h01; lr[1]  = 8'h31; lr[2]  = 8'h32; lr[3]  = 8'h33;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, OP_CALL, tgt[i]); tick();
            checks++; if (bus.PC !== tgt[i] || bus.SP !== 3'(i + 1) || bus.LR_TOP !== lr[i]) begin errors++; $display("FAIL fill_call%0d: got pc=%h sp=%0d lr=%h expected %h/%0d/%h", i, bus.PC, bus.SP, bus.LR_TOP, tgt[i], i + 1, lr[i]); end
        end
        drive(1'b1, OP_CALL, 8'h50); tick();
        checks++; if (bus.STATE !== 2'b10 || bus.STK_OVF !== 1'b1 || bus.STK_UNF !== 1'b0) begin errors++; $display("FAIL ovf_fault: got st=%b ovf=%b unf=%b expected 10/1/0", bus.STATE, bus.STK_OVF, bus.STK_UNF); end
        checks++; if (bus.PC !== 8'hFF || bus.SP !== 3'd4) begin errors++; $display("FAIL ovf_hold: got pc=%h sp=%0d expected FF/4", bus.PC, bus.SP); end
        bus.RESUME = 1'b1; bus.BASE_LD = 1'b1; bus.BASE_DATA = 8'h5C;
        drive(1'b1, OP_RET, 8'h00); tick();
        drive(1'b1, OP_JMP, 8'h77); tick();
        checks++; if (bus.PC !== 8'hFF || bus.SP !== 3'd4 || bus.STATE !== 2'b10) begin errors++; $display("FAIL fault_terminal: got pc=%h sp=%0d st=%b expected FF/4/10", bus.PC, bus.SP, bus.STATE); end
        checks++; if (bus.BASE_REG !== 8'h5C) begin errors++; $display("FAIL fault_base_ld: got %h expected 5C", bus.BASE_REG); end
        idle_inputs();
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        checks++; if (bus.PC !== 8'h00 || bus.SP !== 3'd0 || bus.STATE !== 2'b00 || bus.STK_OVF !== 1'b0 || bus.LR_TOP !== 8'h00 || bus.BASE_REG !== 8'h00) begin errors++; $display("FAIL fault_async_reset: got pc=%h sp=%0d st=%b ovf=%b lr=%h base=%h expected 00/0/00/0/00/00", bus.PC, bus.SP, bus.STATE, bus.STK_OVF, bus.LR_TOP, bus.BASE_REG); end
        #1;
        rst = 1'b0;
        drive(1'b1, OP_CALL, 8'h44); tick();
        checks++; if (bus.SP !== 3'd1 || bus.LR_TOP !== 8'h01 || bus.PC !== 8'h44) begin errors++; $display("FAIL after_reset_call: got sp=%0d lr=%h pc=%h expected 1/01/44", bus.SP, bus.LR_TOP, bus.PC); end
    endtask

    task automatic test_underflow_wrap;
        do_reset();
        drive(1'b1, OP_JMP, 8'h33); tick();
        drive(1'b1, OP_RET, 8'h00); tick();
        checks++; if (bus.STATE !== 2'b10 || bus.STK_UNF !== 1'b1 || bus.STK_OVF !== 1'b0) begin errors++; $display("FAIL unf_fault: got st=%b unf=%b ovf=%b expected 10/1/0", bus.STATE, bus.STK_UNF, bus.STK_OVF); end
        checks++; if (bus.PC !== 8'h33 || bus.SP !== 3'd0) begin errors++; $display("FAIL unf_hold: got pc=%h sp=%0d expected 33/0", bus.PC, bus.SP); end
        do_reset();
        drive(1'b1, OP_JMP, 8'hFF); tick();
        checks++; if (bus.PC !== 8'hFF) begin errors++; $display("FAIL jmp_ff: got %h expected FF", bus.PC); end
        drive(1'b1, OP_NEXT, 8'h00); tick();
        checks++; if (bus.PC !== 8'h00) begin errors++; $display("FAIL next_wrap: got %h expected 00", bus.PC); end
        drive(1'b1, OP_JMP, 8'hFF); tick();
        drive(1'b1, OP_CALL, 8'h08); tick();
        checks++; if (bus.LR_TOP !== 8'h00 || bus.SP !== 3'd1) begin errors++; $display("FAIL call_wrap_lr: got lr=%h sp=%0d expected 00/1", bus.LR_TOP, bus.SP); end
        drive(1'b1, OP_RET, 8'h00); tick();
        checks++; if (bus.PC !== 8'h00 || bus.SP !== 3'd0) begin errors++; $display("FAIL ret_wrap: got pc=%h sp=%0d expected 00/0", bus.PC, bus.SP); end
    endtask

    task automatic test_halt;
        do_reset();
        drive(1'b1, OP_JMP, 8'h20); tick();
        drive(1'b1, OP_HALT, 8'h00); tick();
        checks++; if (bus.PC !== 8'h20 || bus.STATE !== 2'b01) begin errors++; $display("FAIL halt_enter: got pc=%h st=%b expected 20/01", bus.PC, bus.STATE); end
        drive(1'b1, OP_NEXT, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.PC !== 8'h20 || bus.STATE !== 2'b01) begin errors++; $display("FAIL halt_hold%0d: got pc=%h st=%b expected 20/01", i, bus.PC, bus.STATE); end
        end
        drive(1'b0, OP_NEXT, 8'h00);
        bus.RESUME = 1'b1;
        tick();
        bus.RESUME = 1'b0;
        checks++; if (bus.PC !== 8'h21 || bus.STATE !== 2'b00) begin errors++; $display("FAIL resume: got pc=%h st=%b expected 21/00", bus.PC, bus.STATE); end
        drive(1'b1, OP_NEXT, 8'h00); tick();
        checks++; if (bus.PC !== 8'h22) begin errors++; $display("FAIL post_resume_next: got %h expected 22", bus.PC); end
    endtask

    initial begin
        test_reset();
        test_next();
        test_jmpb();
        test_call_ret();
        test_overflow();
        test_underflow_wrap();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
